i2c_slave_regs: RTL and testbench
=================================

I2C_SLAVE_REGS -- requirements
Module: i2c_slave_regs

Interface
REQ-001 SHALL have parameter DEV_ADDR, default 7'h39, the 7-bit I2C device address this block answers to.
REQ-002 SHALL have parameter SYNC_STAGES, default 2, the synchronizer depth applied to scl_i and sda_i.
REQ-003 SHALL have one clock and an asynchronous active-low reset: clk and rst_n (fixed).
REQ-004 SHALL have ports, in this order:
- clk  in  1  system clock, at least 20x the SCL rate
- rst_n  in  1  async active-low reset
- scl_i  in  1  I2C SCL pad input
- sda_i  in  1  I2C SDA pad input
- sda_oe  out  1  1 = pull SDA low (open-drain); 0 = release
- wr_en  out  1  one-clk pulse per byte written
- wr_addr  out  4  register index of the write
- wr_data  out  8  byte written
- host_addr  in  4  local read index
- host_rdata  out  8  combinational register file contents at host_addr
- busy  out  1  high from an address-matched START until STOP or return to IDLE

Function
REQ-005 SHALL pass scl_i and sda_i through SYNC_STAGES flops and detect edges on the synchronized signals only.
REQ-006 SHALL detect START as synchronized SDA falling while SCL is high, and STOP as SDA rising while SCL is high.
REQ-007 SHALL sample SDA on the SCL rising edge and change sda_oe only on the clk after an SCL falling edge.
REQ-008 SHALL use states IDLE, DEV, DEV_ACK, REG, REG_ACK, WDATA, WACK, RDATA, RACK.
REQ-009 Transitions:
- START from any state -> DEV; bit counter cleared
- STOP from any state -> IDLE; sda_oe released the same clk
REQ-010 DEV SHALL shift 8 bits MSB first.
- Upper 7 bits == DEV_ADDR -> DEV_ACK
- Otherwise -> IDLE, no ACK; no further response until the next START
REQ-011 DEV_ACK SHALL drive sda_oe=1 for the 9th SCL period.
- Then R/W=0 -> REG
- Then R/W=1 -> RDATA, loading reg[pointer] into the shifter
REQ-012 REG SHALL receive 8 bits.
- pointer <= byte[3:0]; upper 4 bits ignored
- -> REG_ACK (ACK), then -> WDATA
REQ-013 WDATA SHALL receive 8 bits, then:
- write reg[pointer] and pulse wr_en for one clk on the 8th sampling edge, with wr_addr=pointer and wr_data=byte in that cycle
- pointer <= pointer+1 mod 16 (15 wraps to 0)
- -> WACK (ACK), then -> WDATA
REQ-014 RDATA SHALL drive sda_oe = ~bit, MSB first, one bit per SCL low phase, then -> RACK with SDA released.
REQ-015 RACK SHALL sample the master's bit at SCL rise.
- 0 (ACK): pointer+1 mod 16, load the next byte -> RDATA
- 1 (NACK): pointer+1 mod 16 -> IDLE, sda_oe stays 0
REQ-016 A repeated START SHALL keep the pointer, so a write of the register index followed by a read returns reg[index].
REQ-017 If START and STOP are detected in the same clk, STOP SHALL win.
REQ-018 sda_oe SHALL never be asserted while SCL is high except while holding an ACK or a data bit driven in the preceding low phase.

Reset
REQ-019 While rst_n=0, SHALL hold: state IDLE, sda_oe=0, wr_en=0, wr_addr=0, wr_data=0, busy=0, pointer=0, all 16 registers 8'h00, synchronizers set to 1.
REQ-020 Reset asserted mid-transfer SHALL release SDA immediately (asynchronously); the block SHALL ignore the bus until a fresh START after reset deassertion.

Verification
REQ-021 Write 0x72 (0x39,W), 0x05, 0xA5, 0x5A, STOP -> ACK on all 4 bytes; wr_en pulses with (5,A5) then (6,5A); host_addr=6 gives 5A.
REQ-022 Write reg 0x0F, data 0x11, 0x22 -> writes land at 15 then 0; pointer wraps to 1.
REQ-023 Preload 0x03=C3, 0x04=3C; write 0x72, 0x03, repeated START, 0x73; read 2 bytes (ACK, then NACK) -> SDA carries C3 then 3C; block idle after NACK.
REQ-024 Address 0x74 (mismatch) -> sda_oe stays 0 through the 9th clock; busy=0; a following STOP/START is handled normally.
REQ-025 STOP injected after 4 data bits, then a new write transaction -> no wr_en from the aborted byte; the new transaction completes with ACKs.
REQ-026 rst_n pulled low during a read while sda_oe=1 -> sda_oe=0 within the same clk; registers read 00 afterwards.

Source files
------------

// File: rtl/i2c_slave_regs.sv
`default_nettype none
// ============================================================================
// Module : i2c_slave_regs
// Desc   : I2C target with a 16 x 8 register file and auto-incrementing pointer
// Rev    : 1.0
// ============================================================================
module i2c_slave_regs #(
   parameter logic [6:0] DEV_ADDR    = 7'h39,
   parameter int         SYNC_STAGES = 2
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       scl_i,
   input  logic       sda_i,
   output logic       sda_oe,
   output logic       wr_en,
   output logic [3:0] wr_addr,
   output logic [7:0] wr_data,
   input  logic [3:0] host_addr,
   output logic [7:0] host_rdata,
   output logic       busy
);

   localparam logic [3:0] c_IDLE    = 4'd0;
   localparam logic [3:0] c_DEV     = 4'd1;
   localparam logic [3:0] c_DEV_ACK = 4'd2;
   localparam logic [3:0] c_REG     = 4'd3;
   localparam logic [3:0] c_REG_ACK = 4'd4;
   localparam logic [3:0] c_WDATA   = 4'd5;
   localparam logic [3:0] c_WACK    = 4'd6;
   localparam logic [3:0] c_RDATA   = 4'd7;
   localparam logic [3:0] c_RACK    = 4'd8;

   logic [SYNC_STAGES-1:0] scl_sync_q;
   logic [SYNC_STAGES-1:0] sda_sync_q;
   logic                   scl_prev_q;
   logic                   sda_prev_q;

   generate
      if (SYNC_STAGES > 1) begin : g_sync_chain
         always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
               scl_sync_q <= '1;
               sda_sync_q <= '1;
            end else begin
               scl_sync_q <= {scl_sync_q[SYNC_STAGES-2:0], scl_i};
               sda_sync_q <= {sda_sync_q[SYNC_STAGES-2:0], sda_i};
            end
         end
      end else begin : g_sync_single
         always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
               scl_sync_q <= '1;
               sda_sync_q <= '1;
            end else begin
               scl_sync_q <= scl_i;
               sda_sync_q <= sda_i;
            end
         end
      end
   endgenerate

   logic w_scl;
   logic w_sda;
   logic w_scl_rise;
   logic w_scl_fall;
   logic w_start;
   logic w_stop;

   assign w_scl      = scl_sync_q[SYNC_STAGES-1];
   assign w_sda      = sda_sync_q[SYNC_STAGES-1];
   assign w_scl_rise = w_scl & ~scl_prev_q;
   assign w_scl_fall = ~w_scl & scl_prev_q;
   // Bus conditions need SCL high on both sides of the SDA edge.
   assign w_start    = w_scl & scl_prev_q & sda_prev_q & ~w_sda;
   assign w_stop     = w_scl & scl_prev_q & ~sda_prev_q & w_sda;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         scl_prev_q <= 1'b1;
         sda_prev_q <= 1'b1;
      end else begin
         scl_prev_q <= w_scl;
         sda_prev_q <= w_sda;
      end
   end

   logic [3:0] state_q,   state_d;
   logic [3:0] cnt_q,     cnt_d;
   logic [7:0] shift_q,   shift_d;
   logic [3:0] ptr_q,     ptr_d;
   logic       sda_oe_q,  sda_oe_d;
   logic       wr_en_q,   wr_en_d;
   logic [3:0] wr_addr_q, wr_addr_d;
   logic [7:0] wr_data_q, wr_data_d;
   logic       busy_q,    busy_d;
   logic [7:0] regs_q [16];

   logic [7:0] w_byte;
   logic [3:0] w_ptr_inc;

   assign w_byte    = {shift_q[6:0], w_sda};
   assign w_ptr_inc = ptr_q + 4'd1;

   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      shift_d   = shift_q;
      ptr_d     = ptr_q;
      sda_oe_d  = sda_oe_q;
      wr_en_d   = 1'b0;
      wr_addr_d = wr_addr_q;
      wr_data_d = wr_data_q;
      busy_d    = busy_q;

      if (w_stop) begin
         state_d  = c_IDLE;
         cnt_d    = 4'd0;
         sda_oe_d = 1'b0;
         busy_d   = 1'b0;
      end else if (w_start) begin
         state_d  = c_DEV;
         cnt_d    = 4'd0;
         sda_oe_d = 1'b0;
      end else begin
         case (state_q)
            c_DEV: begin
               if (w_scl_rise) begin
                  shift_d = w_byte;
                  cnt_d   = cnt_q + 4'd1;
                  if (cnt_q == 4'd7) begin
                     cnt_d = 4'd0;
                     if (w_byte[7:1] == DEV_ADDR) begin
                        state_d = c_DEV_ACK;
                        busy_d  = 1'b1;
                     end else begin
                        state_d = c_IDLE;
                        busy_d  = 1'b0;
                     end
                  end
               end
            end
            // ACK states: first SCL fall pulls SDA, the next one releases it.
            c_DEV_ACK: begin
               if (w_scl_fall) begin
                  if (!sda_oe_q) begin
                     sda_oe_d = 1'b1;
                  end else if (shift_q[0]) begin
                     state_d  = c_RDATA;
                     shift_d  = {regs_q[ptr_q][6:0], 1'b0};
                     sda_oe_d = ~regs_q[ptr_q][7];
                     cnt_d    = 4'd1;
                  end else begin
                     state_d  = c_REG;
                     sda_oe_d = 1'b0;
                  end
               end
            end
            c_REG: begin
               if (w_scl_rise) begin
                  shift_d = w_byte;
                  cnt_d   = cnt_q + 4'd1;
                  if (cnt_q == 4'd7) begin
                     cnt_d   = 4'd0;
                     ptr_d   = w_byte[3:0];
                     state_d = c_REG_ACK;
                  end
               end
            end
            c_REG_ACK, c_WACK: begin
               if (w_scl_fall) begin
                  if (!sda_oe_q) begin
                     sda_oe_d = 1'b1;
                  end else begin
                     sda_oe_d = 1'b0;
                     state_d  = c_WDATA;
                  end
               end
            end
            c_WDATA: begin
               if (w_scl_rise) begin
                  shift_d = w_byte;
                  cnt_d   = cnt_q + 4'd1;
                  if (cnt_q == 4'd7) begin
                     cnt_d     = 4'd0;
                     wr_en_d   = 1'b1;
                     wr_addr_d = ptr_q;
                     wr_data_d = w_byte;
                     ptr_d     = w_ptr_inc;
                     state_d   = c_WACK;
                  end
               end
            end
            // cnt counts bits already driven; 0 means a fresh byte awaits its MSB.
            c_RDATA: begin
               if (w_scl_fall) begin
                  if (cnt_q == 4'd8) begin
                     sda_oe_d = 1'b0;
                     state_d  = c_RACK;
                  end else begin
                     sda_oe_d = ~shift_q[7];
                     shift_d  = {shift_q[6:0], 1'b0};
                     cnt_d    = cnt_q + 4'd1;
                  end
               end
            end
            c_RACK: begin
               if (w_scl_rise) begin
                  ptr_d = w_ptr_inc;
                  if (!w_sda) begin
                     shift_d = regs_q[w_ptr_inc];
                     cnt_d   = 4'd0;
                     state_d = c_RDATA;
                  end else begin
                     state_d = c_IDLE;
                     busy_d  = 1'b0;
                  end
               end
            end
            c_IDLE: begin
               busy_d = 1'b0;
            end
            default: begin
               state_d  = c_IDLE;
               sda_oe_d = 1'b0;
               busy_d   = 1'b0;
            end
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= c_IDLE;
         cnt_q     <= 4'd0;
         shift_q   <= 8'h00;
         ptr_q     <= 4'd0;
         sda_oe_q  <= 1'b0;
         wr_en_q   <= 1'b0;
         wr_addr_q <= 4'd0;
         wr_data_q <= 8'h00;
         busy_q    <= 1'b0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         shift_q   <= shift_d;
         ptr_q     <= ptr_d;
         sda_oe_q  <= sda_oe_d;
         wr_en_q   <= wr_en_d;
         wr_addr_q <= wr_addr_d;
         wr_data_q <= wr_data_d;
         busy_q    <= busy_d;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < 16; i++) begin
            regs_q[i] <= 8'h00;
         end
      end else if (wr_en_d) begin
         regs_q[wr_addr_d] <= wr_data_d;
      end
   end

   assign sda_oe     = sda_oe_q;
   assign wr_en      = wr_en_q;
   assign wr_addr    = wr_addr_q;
   assign wr_data    = wr_data_q;
   assign busy       = busy_q;
   assign host_rdata = regs_q[host_addr];

endmodule
`default_nettype wire

// File: tb/tb_i2c_slave_regs.sv
`default_nettype none
// ============================================================================
// Module : tb_i2c_slave_regs
// Desc   : Directed I2C master bench with write/read scoreboards
// Rev    : 1.0
// ============================================================================
module tb_i2c_slave_regs;

   localparam int c_Q = 10;  // clk cycles per quarter SCL period

   logic       clk   = 1'b0;
   logic       rst_n = 1'b0;
   logic       scl_m = 1'b1;
   logic       sda_m = 1'b1;
   logic       sda_oe;
   logic       wr_en;
   logic [3:0] wr_addr;
   logic [7:0] wr_data;
   logic [3:0] host_addr = 4'd0;
   logic [7:0] host_rdata;
   logic       busy;
   logic       sda_line;

   assign sda_line = sda_m & ~sda_oe;

   i2c_slave_regs #(
      .DEV_ADDR    (7'h39),
      .SYNC_STAGES (2)
   ) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .scl_i      (scl_m),
      .sda_i      (sda_line),
      .sda_oe     (sda_oe),
      .wr_en      (wr_en),
      .wr_addr    (wr_addr),
      .wr_data    (wr_data),
      .host_addr  (host_addr),
      .host_rdata (host_rdata),
      .busy       (busy)
   );

   always #5 clk = ~clk;

   int         checks   = 0;
   int         failures = 0;
   logic [11:0] exp_wr[$];
   logic [7:0]  exp_rd[$];
   logic        oe_prev = 1'b0;
   logic        oe_seen = 1'b0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   // Write scoreboard: every wr_en pulse must match the oldest expected write.
   always @(negedge clk) begin
      logic [11:0] e;
      if (rst_n && wr_en) begin
         checks++;
         assert (exp_wr.size() != 0) else begin
            failures++;
            $error("FAIL wr_unexpected observed=%0h/%0h expected=none", wr_addr, wr_data);
         end
         if (exp_wr.size() != 0) begin
            e = exp_wr.pop_front();
            chk("wr_event", 32'({wr_addr, wr_data}), 32'(e));
         end
      end
      if (sda_oe && !oe_prev) chk("oe_rise_scl_low", 32'(scl_m), 32'd0);
      if (sda_oe) oe_seen = 1'b1;
      oe_prev = sda_oe;
   end

   task automatic q();
      repeat (c_Q) @(posedge clk);
      #1;
   endtask

   task automatic i2c_start();
      sda_m = 1'b1; scl_m = 1'b1; q();
      sda_m = 1'b0; q();
      scl_m = 1'b0; q();
   endtask

   task automatic i2c_rstart();
      sda_m = 1'b1; q();
      scl_m = 1'b1; q();
      sda_m = 1'b0; q();
      scl_m = 1'b0; q();
   endtask

   task automatic i2c_stop();
      sda_m = 1'b0; q();
      scl_m = 1'b1; q();
      sda_m = 1'b1; q();
   endtask

   task automatic put_bit(input logic b);
      sda_m = b; q();
      scl_m = 1'b1; q(); q();
      scl_m = 1'b0; q();
   endtask

   task automatic get_bit(output logic b);
      sda_m = 1'b1; q();
      scl_m = 1'b1; q();
      b = sda_line; q();
      scl_m = 1'b0; q();
   endtask

   task automatic send(input logic [7:0] d, input logic exp_ack, input string tag);
      logic a;
      for (int i = 7; i >= 0; i--) put_bit(d[i]);
      get_bit(a);
      chk(tag, 32'(a), 32'(exp_ack));
   endtask

   task automatic recv(input logic nack, input string tag);
      logic [7:0] d;
      logic [7:0] e;
      for (int i = 7; i >= 0; i--) get_bit(d[i]);
      put_bit(nack);
      checks++;
      assert (exp_rd.size() != 0) else begin
         failures++;
         $error("FAIL %s_no_expect observed=0x%0h expected=none", tag, d);
      end
      if (exp_rd.size() != 0) begin
         e = exp_rd.pop_front();
         chk(tag, 32'(d), 32'(e));
      end
   endtask

   task automatic host_chk(input logic [3:0] a, input logic [7:0] e, input string tag);
      host_addr = a;
      #1;
      chk(tag, 32'(host_rdata), 32'(e));
   endtask

   initial begin
      #2ms;
      $display("FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      logic b;

      // Reset state
      repeat (3) @(posedge clk);
      #1;
      chk("rst_sda_oe",  32'(sda_oe),  32'd0);
      chk("rst_wr_en",   32'(wr_en),   32'd0);
      chk("rst_wr_addr", 32'(wr_addr), 32'd0);
      chk("rst_wr_data", 32'(wr_data), 32'd0);
      chk("rst_busy",    32'(busy),    32'd0);
      host_chk(4'd0, 8'h00, "rst_reg0");
      host_chk(4'd9, 8'h00, "rst_reg9");
      @(negedge clk);
      rst_n = 1'b1;
      q();

      // Basic write with auto-increment
      i2c_start();
      send(8'h72, 1'b0, "w1_dev_ack");
      chk("w1_busy", 32'(busy), 32'd1);
      send(8'h05, 1'b0, "w1_reg_ack");
      exp_wr.push_back({4'd5, 8'hA5});
      send(8'hA5, 1'b0, "w1_d0_ack");
      exp_wr.push_back({4'd6, 8'h5A});
      send(8'h5A, 1'b0, "w1_d1_ack");
      i2c_stop();
      chk("w1_busy_after_stop", 32'(busy), 32'd0);
      host_chk(4'd6, 8'h5A, "w1_reg6");
      host_chk(4'd5, 8'hA5, "w1_reg5");

      // Pointer wraps from 15 to 0
      i2c_start();
      send(8'h72, 1'b0, "w2_dev_ack");
      send(8'h0F, 1'b0, "w2_reg_ack");
      exp_wr.push_back({4'd15, 8'h11});
      send(8'h11, 1'b0, "w2_d0_ack");
      exp_wr.push_back({4'd0, 8'h22});
      send(8'h22, 1'b0, "w2_d1_ack");
      exp_wr.push_back({4'd1, 8'h33});
      send(8'h33, 1'b0, "w2_d2_ack");
      i2c_stop();
      host_chk(4'd15, 8'h11, "w2_reg15");
      host_chk(4'd0,  8'h22, "w2_reg0");
      host_chk(4'd1,  8'h33, "w2_reg1");

      // Preload, then write index + repeated START + read two bytes
      i2c_start();
      send(8'h72, 1'b0, "r1_pre_dev");
      send(8'h03, 1'b0, "r1_pre_reg");
      exp_wr.push_back({4'd3, 8'hC3});
      send(8'hC3, 1'b0, "r1_pre_d0");
      exp_wr.push_back({4'd4, 8'h3C});
      send(8'h3C, 1'b0, "r1_pre_d1");
      i2c_stop();
      i2c_start();
      send(8'h72, 1'b0, "r1_dev_w");
      send(8'h03, 1'b0, "r1_reg");
      i2c_rstart();
      send(8'h73, 1'b0, "r1_dev_r");
      chk("r1_busy_read", 32'(busy), 32'd1);
      exp_rd.push_back(8'hC3);
      recv(1'b0, "r1_byte0");
      exp_rd.push_back(8'h3C);
      recv(1'b1, "r1_byte1");
      chk("r1_idle_after_nack", 32'(busy), 32'd0);
      chk("r1_oe_after_nack",   32'(sda_oe), 32'd0);
      i2c_stop();

      // Address mismatch is ignored, then a normal transaction
      oe_seen = 1'b0;
      i2c_start();
      send(8'h74, 1'b1, "m1_no_ack");
      chk("m1_oe_never", 32'(oe_seen), 32'd0);
      chk("m1_busy",     32'(busy),    32'd0);
      i2c_stop();
      i2c_start();
      send(8'h72, 1'b0, "m1_next_dev");
      send(8'h08, 1'b0, "m1_next_reg");
      exp_wr.push_back({4'd8, 8'h77});
      send(8'h77, 1'b0, "m1_next_d0");
      i2c_stop();
      host_chk(4'd8, 8'h77, "m1_reg8");

      // STOP after four data bits aborts the byte
      i2c_start();
      send(8'h72, 1'b0, "a1_dev");
      send(8'h09, 1'b0, "a1_reg");
      put_bit(1'b1); put_bit(1'b0); put_bit(1'b1); put_bit(1'b0);
      i2c_stop();
      chk("a1_busy", 32'(busy), 32'd0);
      host_chk(4'd9, 8'h00, "a1_reg9_untouched");
      i2c_start();
      send(8'h72, 1'b0, "a1_new_dev");
      send(8'h0A, 1'b0, "a1_new_reg");
      exp_wr.push_back({4'd10, 8'h99});
      send(8'h99, 1'b0, "a1_new_d0");
      i2c_stop();
      host_chk(4'd10, 8'h99, "a1_reg10");

      // Reset while the block drives a data bit low
      i2c_start();
      send(8'h72, 1'b0, "x1_dev_w");
      send(8'h03, 1'b0, "x1_reg");
      i2c_rstart();
      send(8'h73, 1'b0, "x1_dev_r");
      get_bit(b);
      chk("x1_bit7", 32'(b), 32'd1);
      get_bit(b);
      chk("x1_bit6", 32'(b), 32'd1);
      for (int i = 0; i < 40 && !sda_oe; i++) @(posedge clk);
      #1;
      chk("x1_oe_before_reset", 32'(sda_oe), 32'd1);
      rst_n = 1'b0;
      #1;
      chk("x1_oe_async_release", 32'(sda_oe), 32'd0);
      scl_m = 1'b1;
      sda_m = 1'b1;
      repeat (3) @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      q();
      chk("x1_busy_after_reset", 32'(busy), 32'd0);
      host_chk(4'd3,  8'h00, "x1_reg3_cleared");
      host_chk(4'd15, 8'h00, "x1_reg15_cleared");
      i2c_start();
      send(8'h72, 1'b0, "x1_post_dev");
      send(8'h02, 1'b0, "x1_post_reg");
      exp_wr.push_back({4'd2, 8'h44});
      send(8'h44, 1'b0, "x1_post_d0");
      i2c_stop();
      host_chk(4'd2, 8'h44, "x1_reg2");

      q();
      chk("wr_queue_drained", 32'(exp_wr.size()), 32'd0);
      chk("rd_queue_drained", 32'(exp_rd.size()), 32'd0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
`default_nettype wire
